// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, default widths and timeout for the generation sequencer
package gol_pkg;
  localparam int ADDR_W = 12;
  localparam int GEN_W = 16;
  localparam int TIMEOUT = 1048576;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_SWAP  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;
  function automatic logic is_phase(input logic [2:0] s);
    return s == S_REQ || s == S_REL || s == S_DRAIN;
  endfunction
endpackage

// File: rtl/gol_phase_watchdog.sv
// gol_phase_watchdog: counts cycles spent in one handshake phase, flags TIMEOUT-1 reached
module gol_phase_watchdog #(
  parameter int TIMEOUT = gol_pkg::TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  assign expired = enable && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer: runs N engine generations over ping-pong boards with a four-phase handshake
module gol_generation_sequencer #(
  parameter int ADDR_W = gol_pkg::ADDR_W,
  parameter int GEN_W = gol_pkg::GEN_W,
  parameter int TIMEOUT = gol_pkg::TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_cfg_start,
  input  logic              io_cfg_abort,
  input  logic [GEN_W-1:0]  io_cfg_generations,
  input  logic [ADDR_W-1:0] io_cfg_buf_a,
  input  logic [ADDR_W-1:0] io_cfg_buf_b,
  output logic              io_eng_initialize,
  input  logic              io_eng_completed,
  output logic [ADDR_W-1:0] io_eng_starting_address,
  output logic [ADDR_W-1:0] io_eng_result_address,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_error,
  output logic              io_aborted,
  output logic [GEN_W-1:0]  io_gen_count,
  output logic [ADDR_W-1:0] io_final_address
);
  import gol_pkg::*;
  logic [2:0] state, nxt;
  logic [ADDR_W-1:0] buf_a, buf_b, src, dst, final_address;
  logic [GEN_W-1:0] gens, gen_count, gen_inc;
  logic start_q, accept, aborted, expired, wd_clear;
  assign accept = io_cfg_start && !start_q && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign gen_inc = gen_count + GEN_W'(1);
  // abort outranks a handshake edge, which outranks the phase timeout
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: nxt = accept ? S_CHECK : state;
      S_CHECK: nxt = io_cfg_abort ? S_DRAIN : buf_a == buf_b ? S_ERROR : gens == '0 ? S_DONE : S_REQ;
      S_REQ:   nxt = io_cfg_abort ? S_DRAIN : io_eng_completed ? S_REL : expired ? S_ERROR : S_REQ;
      S_REL:   nxt = io_cfg_abort ? S_DRAIN : !io_eng_completed ? S_SWAP : expired ? S_ERROR : S_REL;
      S_SWAP:  nxt = io_cfg_abort ? S_DRAIN : gen_inc == gens ? S_DONE : S_REQ;
      S_DRAIN: nxt = !io_eng_completed ? S_IDLE : expired ? S_ERROR : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
  end
  assign wd_clear = nxt != state && is_phase(nxt);
  gol_phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (is_phase(state)),
    .expired (expired)
  );
  // start_q follows the pin even in reset so a start held through reset is not an edge
  always_ff @(posedge clock) begin
    start_q <= io_cfg_start;
    if (reset) begin
      state <= S_IDLE;
      buf_a <= '0;
      buf_b <= '0;
      gens <= '0;
      src <= '0;
      dst <= '0;
      final_address <= '0;
      gen_count <= '0;
      aborted <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        buf_a <= io_cfg_buf_a;
        buf_b <= io_cfg_buf_b;
        gens <= io_cfg_generations;
        src <= io_cfg_buf_a;
        dst <= io_cfg_buf_b;
        gen_count <= '0;
        aborted <= 1'b0;
      end
      if (state == S_SWAP) begin
        gen_count <= gen_inc;
        src <= dst;
        dst <= src;
        final_address <= dst;
      end
      if (state == S_DRAIN && nxt == S_IDLE) aborted <= 1'b1;
    end
  end
  assign io_eng_initialize = state == S_REQ;
  assign io_eng_starting_address = src;
  assign io_eng_result_address = dst;
  assign io_busy = state == S_CHECK || state == S_SWAP || is_phase(state);
  assign io_done = state == S_DONE;
  assign io_error = state == S_ERROR;
  assign io_aborted = aborted;
  assign io_gen_count = gen_count;
  assign io_final_address = final_address;
endmodule

// File: tb/tb_gol_generation_sequencer.sv
// tb_gol_generation_sequencer: scoreboard bench with engine model and randomized runs
module tb_gol_generation_sequencer;
  localparam int AW = 12;
  localparam int GW = 16;
  localparam int TO = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_cfg_start = 1'b0;
  logic io_cfg_abort = 1'b0;
  logic [GW-1:0] io_cfg_generations = '0;
  logic [AW-1:0] io_cfg_buf_a = '0;
  logic [AW-1:0] io_cfg_buf_b = '0;
  logic io_eng_completed = 1'b0;
  logic io_eng_initialize, io_busy, io_done, io_error, io_aborted;
  logic [AW-1:0] io_eng_starting_address, io_eng_result_address, io_final_address;
  logic [GW-1:0] io_gen_count;

  gol_generation_sequencer #(.ADDR_W(AW), .GEN_W(GW), .TIMEOUT(TO)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_cfg_start            (io_cfg_start),
    .io_cfg_abort            (io_cfg_abort),
    .io_cfg_generations      (io_cfg_generations),
    .io_cfg_buf_a            (io_cfg_buf_a),
    .io_cfg_buf_b            (io_cfg_buf_b),
    .io_eng_initialize       (io_eng_initialize),
    .io_eng_completed        (io_eng_completed),
    .io_eng_starting_address (io_eng_starting_address),
    .io_eng_result_address   (io_eng_result_address),
    .io_busy                 (io_busy),
    .io_done                 (io_done),
    .io_error                (io_error),
    .io_aborted              (io_aborted),
    .io_gen_count            (io_gen_count),
    .io_final_address        (io_final_address)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int req_cyc = 0;
  int req_seen = 0;
  int ack_dly = 5;
  int hold_extra = 0;
  int abort_gen = 0;
  bit eng_on = 1'b1;
  logic [2*AW-1:0] exp_q[$];
  logic [2*AW-1:0] mon_e;
  logic [AW-1:0] model_final = '0;
  logic [AW-1:0] cur_s, cur_d;
  logic prev_init = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every new engine request is matched against the next expected board pair.
  always @(negedge clock) begin
    if (io_eng_initialize && !prev_init) begin
      req_seen++;
      req_cyc = cyc;
      cur_s = io_eng_starting_address;
      cur_d = io_eng_result_address;
      if (exp_q.size() == 0) check("unexpected_request", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("start_addr", 32'(io_eng_starting_address), 32'(mon_e[2*AW-1:AW]));
        check("result_addr", 32'(io_eng_result_address), 32'(mon_e[AW-1:0]));
      end
    end else if (io_eng_initialize)
      check("addr_stable", 32'({io_eng_starting_address, io_eng_result_address}), 32'({cur_s, cur_d}));
    prev_init = io_eng_initialize;
  end

  // Engine model: acks ack_dly cycles after a request, releases once the request drops.
  initial forever begin
    @(negedge clock);
    if (eng_on && io_eng_initialize && !reset) begin
      repeat (ack_dly) @(negedge clock);
      if (!io_eng_initialize) continue;
      io_eng_completed = 1'b1;
      if (abort_gen != 0 && 32'(io_gen_count) == abort_gen - 1) begin
        io_cfg_abort = 1'b1;
        @(negedge clock);
        check("abort_drops_init", 32'(io_eng_initialize), 32'd0);
        io_cfg_abort = 1'b0;
        repeat (3) @(negedge clock);
        check("drain_busy", 32'(io_busy), 32'd1);
        io_eng_completed = 1'b0;
      end else begin
        for (int i = 0; i < 50 && io_eng_initialize; i++) @(negedge clock);
        repeat (hold_extra) @(negedge clock);
        io_eng_completed = 1'b0;
      end
    end
  end

  function automatic logic [AW-1:0] final_of(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input int n, input logic [AW-1:0] prev);
    return (a == b || n == 0) ? prev : (n % 2 == 1 ? b : a);
  endfunction

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] b, input int n);
    @(posedge clock); #1;
    io_cfg_buf_a = a;
    io_cfg_buf_b = b;
    io_cfg_generations = GW'(n);
    io_cfg_start = 1'b1;
    @(posedge clock); #1;
    io_cfg_start = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] a, input logic [AW-1:0] b, input int n);
    if (a != b) for (int k = 0; k < n; k++) exp_q.push_back(k % 2 == 0 ? {a, b} : {b, a});
    pulse_start(a, b, n);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && io_busy; i++) @(negedge clock);
    check("run_ends_in_budget", 32'(i < budget), 32'd1);
  endtask

  task automatic check_end(input logic d, input logic e, input int g);
    check("done", 32'(io_done), 32'(d));
    check("error", 32'(io_error), 32'(e));
    check("gen_count", 32'(io_gen_count), 32'(g));
    check("final_addr", 32'(io_final_address), 32'(model_final));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(io_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init"}, 32'(io_eng_initialize), 32'd0);
    check({tag, "_busy"}, 32'(io_busy), 32'd0);
    check({tag, "_done"}, 32'(io_done), 32'd0);
    check({tag, "_error"}, 32'(io_error), 32'd0);
    check({tag, "_aborted"}, 32'(io_aborted), 32'd0);
    check({tag, "_gen"}, 32'(io_gen_count), 32'd0);
    check({tag, "_final"}, 32'(io_final_address), 32'd0);
    check({tag, "_addrs"}, 32'({io_eng_starting_address, io_eng_result_address}), 32'd0);
  endtask

  initial begin
    int i, r0;
    logic [AW-1:0] a, b;
    int n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1 reset = 1'b0;

    start_run(12'h000, 12'h400, 0);
    for (i = 0; i < 3 && !io_done; i++) @(negedge clock);
    check("zero_gen_latency", 32'(i < 3), 32'd1);
    check_end(1'b1, 1'b0, 0);

    ack_dly = 5;
    start_run(12'h000, 12'h400, 3);
    wait_idle(500);
    model_final = final_of(12'h000, 12'h400, 3, model_final);
    check_end(1'b1, 1'b0, 3);

    start_run(12'h200, 12'h200, 2);
    wait_idle(20);
    check_end(1'b0, 1'b1, 0);

    abort_gen = 2;
    start_run(12'h100, 12'h300, 3);
    wait_idle(500);
    abort_gen = 0;
    exp_q.delete();
    model_final = 12'h300;
    check_end(1'b0, 1'b0, 1);
    check("aborted", 32'(io_aborted), 32'd1);

    eng_on = 1'b0;
    start_run(12'h010, 12'h020, 2);
    for (i = 0; i < 200 && !io_error; i++) @(negedge clock);
    check("timeout_cycles", 32'(cyc - req_cyc), 32'd64);
    exp_q.delete();
    check_end(1'b0, 1'b1, 0);
    eng_on = 1'b1;

    ack_dly = 2;
    hold_extra = 3;
    start_run(12'h040, 12'h080, 3);
    r0 = req_seen;
    pulse_start(12'h111, 12'h222, 7);
    for (i = 0; i < 300 && !(req_seen >= r0 + 2 && io_busy && !io_eng_initialize && io_eng_completed); i++)
      @(negedge clock);
    check("reached_rel", 32'(i < 300), 32'd1);
    reset = 1'b1;
    io_cfg_start = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    model_final = '0;
    hold_extra = 0;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("held_start_ignored", 32'(io_busy), 32'd0);
    io_cfg_start = 1'b0;
    repeat (8) @(negedge clock);

    repeat (8) begin
      a = AW'($urandom);
      b = ($urandom_range(0, 4) == 0) ? a : AW'($urandom);
      n = $urandom_range(0, 4);
      ack_dly = $urandom_range(1, 6);
      start_run(a, b, n);
      wait_idle(600);
      model_final = final_of(a, b, n, model_final);
      check_end(a != b, a == b, a == b ? 0 : n);
      repeat (10) @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/gol_generation_sequencer.md
GOL_GENERATION_SEQUENCER -- requirements
Module: gol_generation_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the board-memory word address width.
REQ-002 The block SHALL have parameter GEN_W, default 16, meaning the generation-counter width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1048576, meaning the maximum number of cycles allowed per handshake phase.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port io_cfg_start, input, 1 bit: the run request, sampled on its rising edge only.
REQ-007 The block SHALL have port io_cfg_abort, input, 1 bit: the level abort request.
REQ-008 The block SHALL have port io_cfg_generations, input, GEN_W bits: the number of generations to run.
REQ-009 The block SHALL have ports io_cfg_buf_a and io_cfg_buf_b, input, ADDR_W bits each: the ping-pong board base addresses.
REQ-010 The block SHALL have port io_eng_initialize, output, 1 bit: the per-generation request to the engine.
REQ-011 The block SHALL have port io_eng_completed, input, 1 bit: the engine acknowledge.
REQ-012 The block SHALL have ports io_eng_starting_address and io_eng_result_address, output, ADDR_W bits each: the source and destination boards.
REQ-013 The block SHALL have port io_busy, output, 1 bit: set while a run is in progress.
REQ-014 The block SHALL have ports io_done, io_error and io_aborted, output, 1 bit each: sticky status flags.
REQ-015 The block SHALL have port io_gen_count, output, GEN_W bits: the number of generations completed.
REQ-016 The block SHALL have port io_final_address, output, ADDR_W bits: the base address of the latest complete board.

Function
REQ-017 The state machine SHALL have exactly the states IDLE, CHECK, REQ, REL, SWAP, DRAIN, DONE and ERROR.
REQ-018 A rising edge of io_cfg_start in IDLE, DONE or ERROR SHALL latch all io_cfg_* inputs, clear gen_count and the status flags, set src=buf_a and dst=buf_b, and enter CHECK on the next cycle.
REQ-019 A rising edge of io_cfg_start in any other state SHALL be ignored.
REQ-020 CHECK SHALL go to ERROR if buf_a equals buf_b.
REQ-021 Otherwise, CHECK SHALL go to DONE if generations equals 0, else to REQ.
REQ-022 In REQ, io_eng_initialize SHALL be 1, and the state SHALL move to REL on the first cycle in which io_eng_completed is 1.
REQ-023 In REL, io_eng_initialize SHALL be 0, and the state SHALL move to SWAP on the first cycle in which io_eng_completed is 0 (four-phase handshake).
REQ-024 SWAP SHALL last one cycle in which it increments gen_count, exchanges src and dst, and sets final_address to the old dst.
REQ-025 SWAP SHALL then go to DONE if the new gen_count equals generations, else to REQ.
REQ-026 io_eng_starting_address and io_eng_result_address SHALL equal src and dst, and SHALL be stable whenever io_eng_initialize is 1.
REQ-027 io_busy SHALL be 1 in CHECK, REQ, REL, SWAP and DRAIN.
REQ-028 In DONE, io_done SHALL be 1; in ERROR, io_error SHALL be 1.
REQ-029 io_aborted SHALL be set on the DRAIN-to-IDLE transition and SHALL hold until the next accepted start or reset.
REQ-030 io_cfg_abort=1 in CHECK, REQ, REL or SWAP SHALL enter DRAIN, with io_eng_initialize set to 0 in the same cycle as the transition.
REQ-031 DRAIN SHALL wait for io_eng_completed to be 0, then go to IDLE; gen_count and final_address SHALL keep the last completed generation.
REQ-032 A phase counter SHALL reset on every entry to REQ, REL or DRAIN.
REQ-033 The phase counter reaching TIMEOUT-1 without the awaited edge SHALL force ERROR with io_eng_initialize set to 0.
REQ-034 gen_count SHALL NOT wrap, because the terminal compare stops the run at generations, which is at most 2^GEN_W-1.
REQ-035 If abort and a handshake completion occur in the same cycle, abort SHALL win.

Reset
REQ-036 On reset, the block SHALL be in state IDLE.
REQ-037 On reset, io_eng_initialize, io_busy, io_done, io_error and io_aborted SHALL be 0.
REQ-038 On reset, io_gen_count SHALL be 0, and io_final_address, src and dst SHALL be 0.
REQ-039 On reset, the start edge detector SHALL be cleared so that io_cfg_start held high through reset does not start a run.
REQ-040 Reset asserted mid-run SHALL take effect on the next clock edge regardless of the engine handshake state.

Structure
REQ-041 A shared package gol_pkg SHALL hold the state enumeration, ADDR_W, GEN_W and the default TIMEOUT.
REQ-042 The phase timeout SHALL be one sub-module, gol_phase_watchdog, with inputs clear and enable and output expired.
REQ-043 The design SHALL be within 120-400 lines of RTL with no combinational path from any input to io_eng_initialize.

Verification
REQ-044 The bench SHALL cover: buf_a=0x000, buf_b=0x400, generations=3, with an engine model acknowledging after 5 cycles -> starting addresses 0x000, 0x400, 0x000 in order, then io_done=1, io_gen_count=3 and io_final_address=0x400.
REQ-045 The bench SHALL cover: generations=0 -> io_done=1 within 3 cycles of start, io_eng_initialize never 1, and io_final_address=0x000.
REQ-046 The bench SHALL cover: buf_a=buf_b=0x200 -> io_error=1, io_busy=0 and no engine request.
REQ-047 The bench SHALL cover: abort asserted in the REQ state of generation 2 with io_eng_completed held 1 for 4 more cycles -> io_eng_initialize=0 immediately, then IDLE after io_eng_completed falls, with io_aborted=1 and io_gen_count=1.
REQ-048 The bench SHALL cover: a silent engine with TIMEOUT=64 -> io_error=1 exactly 64 cycles after REQ entry.
REQ-049 The bench SHALL cover: a second start pulse mid-run plus reset asserted during REL -> the pulse is ignored, and after reset all outputs return to their reset values the next cycle.
